// File: rtl/proc_ctrl_pkg.sv
// Shared constants and types for the processor pipeline control unit.
package proc_ctrl_pkg;

   localparam logic PCSEL_INC = 1'b1;
   localparam logic PCSEL_BR  = 1'b0;

   localparam int unsigned ST_F  = 0;
   localparam int unsigned ST_D  = 1;
   localparam int unsigned ST_RF = 2;

   typedef enum logic [2:0] {
      ACT_IDLE,
      ACT_FREEZE,
      ACT_FLUSH,
      ACT_HAZARD,
      ACT_ADVANCE
   } act_e;

endpackage

// File: rtl/hazard_detect.sv
// RAW check of the decode-stage sources against older in-flight destinations.
module hazard_detect
   import proc_ctrl_pkg::*;
#(
   parameter int unsigned STAGES = 5,
   parameter int unsigned REG_W  = 2,
   parameter int unsigned K      = 3
) (
   input  logic [STAGES-1:ST_RF]            v,
   input  logic [STAGES-1:ST_RF]            wr,
   input  logic [STAGES-1:ST_RF][REG_W-1:0] dst,
   input  logic [REG_W-1:0]                 src_a,
   input  logic [REG_W-1:0]                 src_b,
   input  logic                             use_a,
   input  logic                             use_b,
   output logic                             hit
);

   logic [STAGES-1:ST_RF] match;

   // Stages beyond K write the register file early enough to never conflict.
   always_comb begin
      match = '0;
      for (int unsigned k = ST_RF; k < STAGES; k++) begin
         if (k <= K) begin
            match[k] = (use_a && (src_a == dst[k])) || (use_b && (src_b == dst[k]));
         end
      end
   end

   assign hit = |(v & wr & match);

endmodule

// File: rtl/pipeline_control.sv
// Central controller: PC/IR load enables, RAW bubbles, branch flush, freeze
// and a saturating hazard-stall counter for an N-stage pipeline.
module pipeline_control
   import proc_ctrl_pkg::*;
#(
   parameter int unsigned STAGES    = 5,
   parameter int unsigned BR_STAGE  = 3,
   parameter int unsigned REG_W     = 2,
   parameter bit          WB_BYPASS = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              stall_ext,
   input  logic              branch_taken,
   input  logic [REG_W-1:0]  id_src_a,
   input  logic [REG_W-1:0]  id_src_b,
   input  logic              id_use_a,
   input  logic              id_use_b,
   input  logic [REG_W-1:0]  id_dst,
   input  logic              id_writes,
   output logic              PCWrite,
   output logic              PCSel,
   output logic [STAGES-1:0] IRLoad,
   output logic [STAGES-1:0] stage_valid,
   output logic              hazard,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int unsigned K = WB_BYPASS ? STAGES - 2 : STAGES - 1;

   logic [STAGES-1:0]                v_q;
   logic [STAGES-1:ST_RF]            wr_q;
   logic [STAGES-1:ST_RF][REG_W-1:0] dst_q;
   logic                             run_q;
   logic [CNT_W-1:0]                 cnt_q;
   logic                             hit;
   logic                             flush;
   logic                             haz;
   act_e                             act;

   hazard_detect #(
      .STAGES (STAGES),
      .REG_W  (REG_W),
      .K      (K)
   ) u_hazard (
      .v      (v_q[STAGES-1:ST_RF]),
      .wr     (wr_q),
      .dst    (dst_q),
      .src_a  (id_src_a),
      .src_b  (id_src_b),
      .use_a  (id_use_a),
      .use_b  (id_use_b),
      .hit    (hit)
   );

   assign flush = run_q && !stall_ext && branch_taken && v_q[BR_STAGE];
   assign haz   = run_q && v_q[ST_D] && !stall_ext && !flush && hit;

   always_comb begin
      if (!run_q)         act = ACT_IDLE;
      else if (stall_ext) act = ACT_FREEZE;
      else if (flush)     act = ACT_FLUSH;
      else if (haz)       act = ACT_HAZARD;
      else                act = ACT_ADVANCE;
   end

   always_comb begin
      PCWrite = 1'b0;
      PCSel   = 1'b0;
      IRLoad  = '0;
      unique case (act)
         ACT_FREEZE: PCSel = PCSEL_INC;
         ACT_FLUSH: begin
            PCSel   = PCSEL_BR;
            PCWrite = 1'b1;
            IRLoad  = '1;
         end
         ACT_HAZARD: begin
            PCSel        = PCSEL_INC;
            IRLoad       = '1;
            IRLoad[ST_F] = 1'b0;
            IRLoad[ST_D] = 1'b0;
         end
         ACT_ADVANCE: begin
            PCSel   = PCSEL_INC;
            PCWrite = 1'b1;
            IRLoad  = '1;
         end
         default: ;
      endcase
   end

   assign hazard      = haz;
   assign stage_valid = v_q;
   assign stall_cnt   = cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         v_q   <= '0;
         wr_q  <= '0;
         dst_q <= '0;
         run_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         unique case (act)
            ACT_IDLE:   run_q <= 1'b1;
            ACT_FREEZE: ;
            ACT_FLUSH: begin
               // Stages up to BR_STAGE are squashed; older ones keep retiring.
               v_q[ST_F] <= 1'b1;
               for (int unsigned i = ST_D; i <= BR_STAGE; i++) v_q[i] <= 1'b0;
               for (int unsigned i = ST_RF; i <= BR_STAGE; i++) wr_q[i] <= 1'b0;
               for (int unsigned i = BR_STAGE; i < STAGES - 1; i++) begin
                  v_q[i+1]   <= v_q[i];
                  wr_q[i+1]  <= wr_q[i];
                  dst_q[i+1] <= dst_q[i];
               end
            end
            ACT_HAZARD: begin
               v_q[ST_RF]  <= 1'b0;
               wr_q[ST_RF] <= 1'b0;
               for (int unsigned i = ST_RF; i < STAGES - 1; i++) begin
                  v_q[i+1]   <= v_q[i];
                  wr_q[i+1]  <= wr_q[i];
                  dst_q[i+1] <= dst_q[i];
               end
               if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end
            ACT_ADVANCE: begin
               v_q          <= {v_q[STAGES-2:0], 1'b1};
               dst_q[ST_RF] <= id_dst;
               wr_q[ST_RF]  <= id_writes && v_q[ST_D];
               for (int unsigned i = ST_RF; i < STAGES - 1; i++) begin
                  wr_q[i+1]  <= wr_q[i];
                  dst_q[i+1] <= dst_q[i];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: default-depth unit plus a 2-bit
// counter variant driven in lockstep for the saturation scenario.
module tb_pipeline_control;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       stall_ext = 1'b0;
   logic       branch_taken = 1'b0;
   logic [1:0] id_src_a = '0;
   logic [1:0] id_src_b = '0;
   logic       id_use_a = 1'b0;
   logic       id_use_b = 1'b0;
   logic [1:0] id_dst = '0;
   logic       id_writes = 1'b0;

   logic        PCWrite, PCSel, hazard;
   logic [4:0]  IRLoad, stage_valid;
   logic [15:0] stall_cnt;

   logic        s_PCWrite, s_PCSel, s_hazard;
   logic [4:0]  s_IRLoad, s_stage_valid;
   logic [1:0]  s_stall_cnt;

   always #5 clock = ~clock;

   pipeline_control #(
      .STAGES(5), .BR_STAGE(3), .REG_W(2), .WB_BYPASS(1'b1), .CNT_W(16)
   ) u_dut (
      .clock(clock), .reset(reset), .stall_ext(stall_ext), .branch_taken(branch_taken),
      .id_src_a(id_src_a), .id_src_b(id_src_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
      .id_dst(id_dst), .id_writes(id_writes), .PCWrite(PCWrite), .PCSel(PCSel),
      .IRLoad(IRLoad), .stage_valid(stage_valid), .hazard(hazard), .stall_cnt(stall_cnt)
   );

   pipeline_control #(
      .STAGES(5), .BR_STAGE(3), .REG_W(2), .WB_BYPASS(1'b1), .CNT_W(2)
   ) u_sat (
      .clock(clock), .reset(reset), .stall_ext(stall_ext), .branch_taken(branch_taken),
      .id_src_a(id_src_a), .id_src_b(id_src_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
      .id_dst(id_dst), .id_writes(id_writes), .PCWrite(s_PCWrite), .PCSel(s_PCSel),
      .IRLoad(s_IRLoad), .stage_valid(s_stage_valid), .hazard(s_hazard), .stall_cnt(s_stall_cnt)
   );

   typedef enum int {F_PCW, F_PCSEL, F_IRL, F_V, F_HAZ, F_CNT, F_SAT} field_e;
   typedef struct {
      string       tag;
      field_e      field;
      logic [31:0] value;
   } exp_t;

   exp_t        sb[$];
   int unsigned checks = 0;
   int unsigned failures = 0;
   int          sat_exp[7] = '{0, 1, 2, 3, 3, 3, 3};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input field_e f);
      case (f)
         F_PCW:   return 32'(PCWrite);
         F_PCSEL: return 32'(PCSel);
         F_IRL:   return 32'(IRLoad);
         F_V:     return 32'(stage_valid);
         F_HAZ:   return 32'(hazard);
         F_CNT:   return 32'(stall_cnt);
         default: return 32'(s_stall_cnt);
      endcase
   endfunction

   task automatic push(input string tag, input field_e f, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.field = f;
      e.value = val;
      sb.push_back(e);
   endtask

   task automatic exp_ctl(input string tag, input logic pcw, input logic [4:0] irl, input logic haz);
      push({tag, ".pcwrite"}, F_PCW, 32'(pcw));
      push({tag, ".irload"}, F_IRL, 32'(irl));
      push({tag, ".hazard"}, F_HAZ, 32'(haz));
   endtask

   task automatic exp_sel(input string tag, input logic sel);
      push({tag, ".pcsel"}, F_PCSEL, 32'(sel));
   endtask

   task automatic exp_v(input string tag, input logic [4:0] v);
      push({tag, ".valid"}, F_V, 32'(v));
   endtask

   task automatic exp_cnt(input string tag, input int c);
      push({tag, ".stall_cnt"}, F_CNT, 32'(c));
   endtask

   task automatic exp_sat(input string tag, input int c);
      push({tag, ".sat_cnt"}, F_SAT, 32'(c));
   endtask

   // Expectations queued for the current cycle are compared mid-cycle.
   task automatic cycle();
      @(negedge clock);
      while (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         check(e.tag, observe(e.field), e.value);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic refill(input string tag);
      logic [4:0] v;
      for (int k = 0; k < 6; k++) begin
         v = 5'((32'd1 << k) - 1);
         exp_ctl(tag, 1'b1, 5'b11111, 1'b0);
         exp_sel(tag, 1'b1);
         exp_v(tag, v);
         cycle();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clock);
      #1;
      // reset held, then first cycle after release
      exp_ctl("rst", 1'b0, 5'b00000, 1'b0); exp_sel("rst", 1'b0);
      exp_v("rst", 5'b00000); exp_cnt("rst", 0); exp_sat("rst", 0);
      cycle();
      reset = 1'b0;
      exp_ctl("rel", 1'b0, 5'b00000, 1'b0); exp_sel("rel", 1'b0); exp_v("rel", 5'b00000);
      cycle();
      refill("fill");

      // RAW back-to-back on r2
      id_writes = 1'b1; id_dst = 2'd2;
      exp_ctl("raw.prod", 1'b1, 5'b11111, 1'b0); exp_v("raw.prod", 5'b11111);
      cycle();
      id_writes = 1'b0; id_use_a = 1'b1; id_src_a = 2'd2;
      exp_ctl("raw.h1", 1'b0, 5'b11100, 1'b1); exp_v("raw.h1", 5'b11111); exp_cnt("raw.h1", 0);
      cycle();
      exp_ctl("raw.h2", 1'b0, 5'b11100, 1'b1); exp_v("raw.h2", 5'b11011); exp_cnt("raw.h2", 1);
      cycle();
      exp_ctl("raw.wb", 1'b1, 5'b11111, 1'b0); exp_sel("raw.wb", 1'b1);
      exp_v("raw.wb", 5'b10011); exp_cnt("raw.wb", 2);
      cycle();
      id_use_a = 1'b0;

      // branch flush overriding a coincident hazard
      id_writes = 1'b1; id_dst = 2'd1;
      exp_ctl("fl.prod", 1'b1, 5'b11111, 1'b0); exp_v("fl.prod", 5'b00111);
      cycle();
      id_writes = 1'b0; id_use_a = 1'b1; id_src_a = 2'd1; branch_taken = 1'b1;
      exp_ctl("fl.br", 1'b1, 5'b11111, 1'b0); exp_sel("fl.br", 1'b0);
      exp_v("fl.br", 5'b01111); exp_cnt("fl.br", 2);
      cycle();
      exp_ctl("fl.ign", 1'b1, 5'b11111, 1'b0); exp_sel("fl.ign", 1'b1);
      exp_v("fl.ign", 5'b10001); exp_cnt("fl.ign", 2);
      cycle();
      branch_taken = 1'b0; id_use_a = 1'b0;

      // freeze during a pending hazard
      id_writes = 1'b1; id_dst = 2'd3;
      exp_ctl("fz.prod", 1'b1, 5'b11111, 1'b0); exp_v("fz.prod", 5'b00011);
      cycle();
      id_writes = 1'b0; id_use_b = 1'b1; id_src_b = 2'd3; stall_ext = 1'b1;
      for (int n = 0; n < 3; n++) begin
         exp_ctl("fz.hold", 1'b0, 5'b00000, 1'b0); exp_v("fz.hold", 5'b00111); exp_cnt("fz.hold", 2);
         cycle();
      end
      stall_ext = 1'b0;
      exp_ctl("fz.h1", 1'b0, 5'b11100, 1'b1); exp_v("fz.h1", 5'b00111); exp_cnt("fz.h1", 2);
      cycle();
      exp_ctl("fz.h2", 1'b0, 5'b11100, 1'b1); exp_v("fz.h2", 5'b01011); exp_cnt("fz.h2", 3);
      cycle();
      exp_ctl("fz.go", 1'b1, 5'b11111, 1'b0); exp_v("fz.go", 5'b10011); exp_cnt("fz.go", 4);
      cycle();
      id_use_b = 1'b0;

      // reset coinciding with a flush
      exp_ctl("rf.pre", 1'b1, 5'b11111, 1'b0); exp_v("rf.pre", 5'b00111);
      cycle();
      branch_taken = 1'b1; reset = 1'b1;
      exp_ctl("rf.br", 1'b1, 5'b11111, 1'b0); exp_sel("rf.br", 1'b0); exp_v("rf.br", 5'b01111);
      cycle();
      branch_taken = 1'b0; reset = 1'b0;
      exp_ctl("rf.rst", 1'b0, 5'b00000, 1'b0); exp_sel("rf.rst", 1'b0);
      exp_v("rf.rst", 5'b00000); exp_cnt("rf.rst", 0); exp_sat("rf.rst", 0);
      cycle();
      refill("rf.fill");

      // saturation: three producer/consumer rounds of two stall cycles each
      id_writes = 1'b1; id_dst = 2'd0;
      exp_ctl("sat.prod", 1'b1, 5'b11111, 1'b0);
      cycle();
      for (int r = 0; r < 3; r++) begin
         id_writes = 1'b0; id_use_a = 1'b1; id_src_a = 2'd0;
         exp_ctl("sat.h1", 1'b0, 5'b11100, 1'b1); exp_cnt("sat.h1", 2*r); exp_sat("sat.h1", sat_exp[2*r]);
         cycle();
         exp_ctl("sat.h2", 1'b0, 5'b11100, 1'b1); exp_cnt("sat.h2", 2*r+1); exp_sat("sat.h2", sat_exp[2*r+1]);
         cycle();
         id_writes = 1'b1; id_dst = 2'd0;
         exp_ctl("sat.n", 1'b1, 5'b11111, 1'b0); exp_cnt("sat.n", 2*r+2); exp_sat("sat.n", sat_exp[2*r+2]);
         cycle();
      end
      id_writes = 1'b0; id_use_a = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
